// File: rtl/aec_postfix_conv.sv
// Infix-to-postfix converter: buffers an ASCII expression and reorders it with an operator stack.
// Latency: a character written at posedge N is processed at N+1; its token is registered there.
// Backpressure: none either way; input is fully buffered, token stream has no ready.
//
// Ports: clk, rst (async active-low); ready/ascii_in = expression stream (ready with first char);
//        tok_valid/tok_is_op/tok_data = postfix token stream (op 0 '+', 1 '-', 2 '*', 15 END);
//        busy = expression in progress; err = sticky error for the current expression.
module aec_postfix_conv #(
    parameter int FIFO_DEPTH  = 32,
    parameter int STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] ascii_in,
    output logic       tok_valid,
    output logic       tok_is_op,
    output logic [3:0] tok_data,
    output logic       busy,
    output logic       err
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = FAW + 1;
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    // Stack entry encoding: operator codes 0..2 match the token op codes.
    localparam logic [1:0] LPAR = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_END} state_t;

    state_t           state;
    logic             capturing;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]   wr_ptr, rd_ptr;
    logic [FCW-1:0]   fcnt;
    logic [1:0]       stk_mem [STACK_DEPTH];
    logic [SPW-1:0]   sp;

    // Status
    logic             fifo_empty, fifo_full, stk_empty, stk_full;
    logic [7:0]       head;
    logic [SPW-2:0]   top_idx;
    logic [1:0]       top;
    logic             top_is_op;

    // Head decode
    logic             h_num, h_op, h_lp, h_rp, h_eq;
    logic [3:0]       h_val;
    logic [1:0]       h_opc;

    // Capture
    logic             accept, cap_en, in_legal, in_eq, fifo_wr, cap_err, ready_err;

    // Processing actions
    logic             fifo_pop, push_req, push_ok, stk_pop, emit, emit_op, fsm_err;
    logic             go_flush, go_end;
    logic [1:0]       push_code;
    logic [3:0]       emit_data;

    always_comb begin
        fifo_empty = (fcnt == '0);
        fifo_full  = (fcnt == FCW'(FIFO_DEPTH));
        head       = fifo_mem[rd_ptr];
        stk_empty  = (sp == '0);
        stk_full   = (sp == SPW'(STACK_DEPTH));
        top_idx    = sp[SPW-2:0] - (SPW-1)'(1);
        top        = stk_mem[top_idx];
        top_is_op  = (top != LPAR);

        h_num = (head >= 8'h30 && head <= 8'h39) || (head >= 8'h61 && head <= 8'h66);
        // '0'-'9' carry their value in the low nibble; 'a'-'f' are 0x61.. so add 9.
        h_val = (head <= 8'h39) ? head[3:0] : head[3:0] + 4'd9;
        h_op  = (head == 8'h2B) || (head == 8'h2D) || (head == 8'h2A);
        h_opc = (head == 8'h2A) ? 2'd2 : ((head == 8'h2D) ? 2'd1 : 2'd0);
        h_lp  = (head == 8'h28);
        h_rp  = (head == 8'h29);
        h_eq  = (head == 8'h3D);
    end

    always_comb begin
        accept   = (state == S_IDLE) && !busy && ready;
        cap_en   = accept || capturing;
        in_eq    = (ascii_in == 8'h3D);
        in_legal = (ascii_in >= 8'h30 && ascii_in <= 8'h39) ||
                   (ascii_in >= 8'h61 && ascii_in <= 8'h66) ||
                   (ascii_in == 8'h2B) || (ascii_in == 8'h2D) || (ascii_in == 8'h2A) ||
                   (ascii_in == 8'h28) || (ascii_in == 8'h29) || in_eq;
        // A full FIFO still accepts a write when the head is being consumed this cycle.
        fifo_wr   = cap_en && in_legal && (!fifo_full || fifo_pop);
        cap_err   = cap_en && (!in_legal || (fifo_full && !fifo_pop));
        ready_err = ready && !accept;
    end

    always_comb begin
        fifo_pop  = 1'b0;
        push_req  = 1'b0;
        push_code = 2'd0;
        stk_pop   = 1'b0;
        emit      = 1'b0;
        emit_op   = 1'b0;
        emit_data = 4'd0;
        fsm_err   = 1'b0;
        go_flush  = 1'b0;
        go_end    = 1'b0;
        case (state)
            S_RUN: begin
                if (!fifo_empty) begin
                    if (h_num) begin
                        emit      = 1'b1;
                        emit_data = h_val;
                        fifo_pop  = 1'b1;
                    end else if (h_lp) begin
                        push_req  = 1'b1;
                        push_code = LPAR;
                        fifo_pop  = 1'b1;
                    end else if (h_op) begin
                        // '*' has precedence 1, '+'/'-' have 0; ties pop (left-assoc).
                        if (!stk_empty && top_is_op && (top == 2'd2 || h_opc != 2'd2)) begin
                            emit      = 1'b1;
                            emit_op   = 1'b1;
                            emit_data = {2'b00, top};
                            stk_pop   = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_code = h_opc;
                            fifo_pop  = 1'b1;
                        end
                    end else if (h_rp) begin
                        if (stk_empty) begin
                            fsm_err  = 1'b1;
                            fifo_pop = 1'b1;
                        end else if (top_is_op) begin
                            emit      = 1'b1;
                            emit_op   = 1'b1;
                            emit_data = {2'b00, top};
                            stk_pop   = 1'b1;
                        end else begin
                            stk_pop  = 1'b1;
                            fifo_pop = 1'b1;
                        end
                    end else if (h_eq) begin
                        fifo_pop = 1'b1;
                        go_flush = 1'b1;
                    end
                end else if (!capturing) begin
                    // Capture ended with an empty FIFO: the '=' was dropped on a full FIFO.
                    go_flush = 1'b1;
                end
            end
            S_FLUSH: begin
                if (stk_empty) begin
                    go_end = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    if (top_is_op) begin
                        emit      = 1'b1;
                        emit_op   = 1'b1;
                        emit_data = {2'b00, top};
                    end else begin
                        fsm_err = 1'b1;
                    end
                    // Popping the last entry goes straight to END to save a cycle.
                    go_end = (sp == SPW'(1));
                end
            end
            default: ;
        endcase
        push_ok = push_req && !stk_full;
        if (push_req && stk_full) fsm_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            capturing <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcnt      <= '0;
            sp        <= '0;
            tok_valid <= 1'b0;
            tok_is_op <= 1'b0;
            tok_data  <= 4'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tok_valid <= 1'b0;
            if (emit) begin
                tok_valid <= 1'b1;
                tok_is_op <= emit_op;
                tok_data  <= emit_data;
            end
            case (state)
                S_IDLE: begin
                    // busy stays up through the END token cycle and drops here.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (accept) begin
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN:   if (go_flush) state <= S_FLUSH;
                S_FLUSH: if (go_end) state <= S_END;
                S_END: begin
                    tok_valid <= 1'b1;
                    tok_is_op <= 1'b1;
                    tok_data  <= 4'hF;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (accept)                      capturing <= !in_eq;
            else if (capturing && in_eq)     capturing <= 1'b0;

            if (fifo_wr)  wr_ptr <= wr_ptr + FAW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + FAW'(1);
            fcnt <= fcnt + FCW'(fifo_wr) - FCW'(fifo_pop);

            if (push_ok)      sp <= sp + SPW'(1);
            else if (stk_pop) sp <= sp - SPW'(1);

            if (accept)                              err <= cap_err;
            else if (cap_err || ready_err || fsm_err) err <= 1'b1;
        end
    end

    // Storage arrays carry no reset; validity is tracked by fcnt and sp.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= ascii_in;
        if (push_ok) stk_mem[sp[SPW-2:0]] <= push_code;
    end
endmodule

// File: doc/aec_postfix_conv.md
# aec_postfix_conv

Infix-to-postfix converter for the arithmetic expression calculator. It captures the ASCII expression stream that upstream drives (a `ready` pulse with the first character, then one character per cycle up to and including `=`). It reorders the expression with an operator stack and emits a postfix token stream, one token per cycle at most, to the evaluator. It buffers the whole expression internally, so upstream never stalls.

## Interface

- `FIFO_DEPTH`, 32: input character buffer entries; max expression length including `=`.
- `STACK_DEPTH`, 16: operator stack entries.

- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `ready` in 1: one-cycle pulse, valid with the first character of an expression.
- `ascii_in` in 8: expression character, sampled every posedge.
- `tok_valid` out 1: one-cycle pulse per token.
- `tok_is_op` out 1: 1 = operator/END token, 0 = operand.
- `tok_data` out 4: operand value 0-15, or op code (0 `+`, 1 `-`, 2 `*`, 15 END).
- `busy` out 1: expression in progress, from `ready` sample until END is emitted.
- `err` out 1: sticky error flag for the current expression.

## Operation

- **Character set.**
  - `0`-`9` map to 0-9 and `a`-`f` map to 10-15; these are operands.
  - `+ - * ( ) =` are the remaining legal characters.
  - Any other character is dropped and sets `err`.
- **Capture.**
  - A `ready`=1 sample at posedge while idle: write `ascii_in` to the FIFO, set `busy`, clear `err`, enter capture.
  - Each later posedge writes `ascii_in` until the `=` character has been written; capture then stops.
  - FIFO full on a write: drop the character and set `err`. A dropped `=` still ends capture.
- **FSM states: IDLE, RUN, FLUSH, END.**
  - IDLE: wait for `ready`.
  - RUN: process the FIFO head, at most one head character per cycle. Processing overlaps capture.
  - FLUSH: pop the operator stack.
  - END: emit the END token, then return to IDLE.
- **RUN rules, head character c:**
  - Operand: emit the operand token, pop the FIFO.
  - `(`: push, pop the FIFO, no token.
  - Operator: if the stack top is an operator with precedence ≥ c's, emit the top and pop the stack, keeping c at the head. Otherwise push c and pop the FIFO.
    - `*` outranks `+` and `-`, which are equal; all are left-associative.
  - `)`:
    - Top is an operator: emit it and pop the stack, keep `)`.
    - Top is `(`: pop both.
    - Stack empty: set `err`, pop the FIFO.
  - `=`: pop the FIFO, go to FLUSH.
  - FIFO empty: idle cycle, stay in RUN.
- **FLUSH.**
  - Top is an operator: emit and pop.
  - Top is `(`: pop without a token, set `err`.
  - Stack empty: go to END.
- **Overflow.** A push onto a full stack is discarded and sets `err`; processing continues.
- **Error handling.** The token stream is still terminated with END. The evaluator qualifies its result with `err`.
- **Widths.** FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth; a separate count is used for full/empty. The stack pointer is log2(`STACK_DEPTH`)+1 bits.

## Timing

- **Reset.** `rst` low forces all outputs to 0, FSM to IDLE, FIFO and stack empty, at any time including mid-expression. Operation resumes on the first `ready` after release.
- **Latency.** A character written at posedge N can be processed at posedge N+1 at the earliest. Its token is registered there, so `tok_valid` is high in the cycle after posedge N+1.
- **Token timing.** Tokens are registered outputs. `tok_valid` is high for exactly one cycle per token. There is no downstream backpressure.
- **`busy`.** Rises after the `ready` sample edge. Falls on the same edge that deasserts the END `tok_valid`.
- **`ready` while `busy`=1.** Ignored; sets `err`.
- **Back-to-back expressions.** A `ready` in the cycle after `busy` falls is accepted.
- **Simultaneous FIFO write/read.** Legal in the same cycle, including when the FIFO holds one entry or is full.
- **`err`.** Updates on the edge of the offending event. Holds until the next accepted `ready` or reset.

## Test plan

- `"1+2="` → tokens 1, 2, op0, END; `err`=0; `busy` spans 7 cycles or fewer.
- `"2+3*4="` → 2, 3, 4, op2, op0, END; `"8-2-1="` → 8, 2, op1, 1, op1, END (left-assoc).
- `"(a-3)*(f+1)="` → 10, 3, op1, 15, 1, op0, op2, END; `err`=0.
- `"3)="` → 3, END, `err`=1. `"(3="` → 3, END, `err`=1. `"3#="` → 3, END, `err`=1.
- Reset mid-stream:
  - Drive `rst` low after `"1+"` is captured → all outputs 0 within the same cycle.
  - After release, `"5="` → 5, END, `err`=0.
- Capacity and reuse:
  - 17 nested `(` → overflow, `err`=1, END still emitted.
  - Two expressions back-to-back with `ready` one cycle after `busy` falls → both streams correct.
